// File: rtl/doorlock_pkg.sv
// +----------------------------------------------------------------------+
// | doorlock_pkg : shared types and constants for the door-lock datapath |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package doorlock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CHECK   = 2'd1,
        ST_OPEN    = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;

    localparam logic [127:0] PW_EMPTY    = {128{1'b1}};
    localparam logic [3:0]   DIGIT_BLANK = 4'hF;
    localparam int           MIN_DIGITS  = 4;

endpackage

`default_nettype wire

// File: rtl/pw_digit_count.sv
// +----------------------------------------------------------------------+
// | pw_digit_count : counts leading decimal digits and checks F padding  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pw_digit_count
    import doorlock_pkg::*;
(
    input  logic [127:0] entry,
    output logic [5:0]   ndig,
    output logic         valid
);

    logic [31:0] w_is_digit;
    logic [31:0] w_is_blank;
    logic [5:0]  w_cnt;
    logic        w_run;
    logic        w_tail_ok;

    for (genvar gi = 0; gi < 32; gi++) begin : g_nib
        assign w_is_digit[gi] = (entry[4*gi +: 4] <= 4'd9);
        assign w_is_blank[gi] = (entry[4*gi +: 4] == DIGIT_BLANK);
    end

    // Once the digit run ends, every remaining nibble must be padding.
    always_comb begin
        w_cnt     = '0;
        w_run     = 1'b1;
        w_tail_ok = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (w_run && w_is_digit[i]) begin
                w_cnt = w_cnt + 6'd1;
            end else begin
                w_run = 1'b0;
                if (!w_is_blank[i]) begin
                    w_tail_ok = 1'b0;
                end
            end
        end
    end

    assign ndig  = w_cnt;
    assign valid = w_tail_ok && (w_cnt >= 6'(MIN_DIGITS));

endmodule

`default_nettype wire

// File: rtl/pw_verifier.sv
// +----------------------------------------------------------------------+
// | pw_verifier : enrolls / verifies keypad passwords, drives door state |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module pw_verifier
    import doorlock_pkg::*;
#(
    parameter int MAX_FAIL    = 3,
    parameter int OPEN_CYCLES = 500,
    parameter int LOCK_CYCLES = 1000
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [127:0]                  entry,
    input  logic                          enter,
    input  logic                          set_mode,
    output logic                          clear_req,
    output logic                          unlocked,
    output logic                          lockout,
    output logic                          pass,
    output logic                          fail,
    output logic                          reject,
    output logic                          enrolled,
    output logic                          programmed,
    output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
);

    localparam int c_FC_W    = $clog2(MAX_FAIL + 1);
    localparam int c_TMR_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX + 1);

    localparam logic [c_FC_W-1:0]  c_FC_MAX    = c_FC_W'(MAX_FAIL);
    localparam logic [c_TMR_W-1:0] c_OPEN_LOAD = c_TMR_W'(OPEN_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_LOCK_LOAD = c_TMR_W'(LOCK_CYCLES - 1);

    state_t              r_state, w_state_nx;
    logic [127:0]        r_snap, w_snap_nx;
    logic [127:0]        r_stored, w_stored_nx;
    logic                r_snap_set, w_snap_set_nx;
    logic                r_snap_open, w_snap_open_nx;
    logic                r_prog, w_prog_nx;
    logic [c_FC_W-1:0]   r_fc, w_fc_nx, w_fc_inc;
    logic [c_TMR_W-1:0]  r_tmr, w_tmr_nx;
    logic                w_clear, w_pass, w_fail, w_reject, w_enrolled;
    logic [5:0]          w_ndig;
    logic                w_valid;
    logic                w_entry_ok;

    pw_digit_count u_digit_count (
        .entry (r_snap),
        .ndig  (w_ndig),
        .valid (w_valid)
    );

    assign w_entry_ok = w_valid && (w_ndig >= 6'(MIN_DIGITS));
    assign w_fc_inc   = (r_fc == c_FC_MAX) ? r_fc : r_fc + c_FC_W'(1);

    always_comb begin
        w_state_nx     = r_state;
        w_snap_nx      = r_snap;
        w_snap_set_nx  = r_snap_set;
        w_snap_open_nx = r_snap_open;
        w_stored_nx    = r_stored;
        w_prog_nx      = r_prog;
        w_fc_nx        = r_fc;
        w_tmr_nx       = r_tmr;
        w_clear        = 1'b0;
        w_pass         = 1'b0;
        w_fail         = 1'b0;
        w_reject       = 1'b0;
        w_enrolled     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (enter) begin
                    w_snap_nx      = entry;
                    w_snap_set_nx  = set_mode;
                    w_snap_open_nx = 1'b0;
                    w_state_nx     = ST_CHECK;
                end
            end

            // An accepted enter wins over timer expiry; the timer holds through CHECK.
            ST_OPEN: begin
                if (enter) begin
                    w_snap_nx      = entry;
                    w_snap_set_nx  = set_mode;
                    w_snap_open_nx = 1'b1;
                    w_state_nx     = ST_CHECK;
                end else if (r_tmr == '0) begin
                    w_state_nx = ST_IDLE;
                end else begin
                    w_tmr_nx = r_tmr - c_TMR_W'(1);
                end
            end

            ST_CHECK: begin
                w_clear    = 1'b1;
                w_state_nx = ST_IDLE;
                if (!w_entry_ok) begin
                    w_reject = 1'b1;
                    if (r_snap_open) begin
                        w_state_nx = ST_OPEN;
                    end
                end else if (r_snap_set && (!r_prog || r_snap_open)) begin
                    w_stored_nx = r_snap;
                    w_prog_nx   = 1'b1;
                    w_enrolled  = 1'b1;
                end else if (r_snap_set) begin
                    w_reject = 1'b1;
                end else if (r_snap_open) begin
                    // Verify while open just relocks the door.
                    w_state_nx = ST_IDLE;
                end else if (!r_prog) begin
                    w_reject = 1'b1;
                end else if (r_snap == r_stored) begin
                    w_pass     = 1'b1;
                    w_fc_nx    = '0;
                    w_tmr_nx   = c_OPEN_LOAD;
                    w_state_nx = ST_OPEN;
                end else begin
                    w_fail  = 1'b1;
                    w_fc_nx = w_fc_inc;
                    if (w_fc_inc == c_FC_MAX) begin
                        w_tmr_nx   = c_LOCK_LOAD;
                        w_state_nx = ST_LOCKOUT;
                    end
                end
            end

            ST_LOCKOUT: begin
                if (r_tmr == '0) begin
                    w_fc_nx    = '0;
                    w_state_nx = ST_IDLE;
                end else begin
                    w_tmr_nx = r_tmr - c_TMR_W'(1);
                end
            end

            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= ST_IDLE;
            r_snap      <= PW_EMPTY;
            r_snap_set  <= 1'b0;
            r_snap_open <= 1'b0;
            r_stored    <= PW_EMPTY;
            r_prog      <= 1'b0;
            r_fc        <= '0;
            r_tmr       <= '0;
            clear_req   <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            reject      <= 1'b0;
            enrolled    <= 1'b0;
            unlocked    <= 1'b0;
            lockout     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_snap      <= w_snap_nx;
            r_snap_set  <= w_snap_set_nx;
            r_snap_open <= w_snap_open_nx;
            r_stored    <= w_stored_nx;
            r_prog      <= w_prog_nx;
            r_fc        <= w_fc_nx;
            r_tmr       <= w_tmr_nx;
            clear_req   <= w_clear;
            pass        <= w_pass;
            fail        <= w_fail;
            reject      <= w_reject;
            enrolled    <= w_enrolled;
            unlocked    <= (w_state_nx == ST_OPEN);
            lockout     <= (w_state_nx == ST_LOCKOUT);
        end
    end

    assign programmed = r_prog;
    assign fail_cnt   = r_fc;

endmodule

`default_nettype wire

// File: tb/tb_pw_verifier.sv
// +----------------------------------------------------------------------+
// | tb_pw_verifier : vector table, directed sequences and random traffic |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_pw_verifier;

    localparam int MAX_FAIL    = 3;
    localparam int OPEN_CYCLES = 500;
    localparam int LOCK_CYCLES = 1000;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [127:0] entry = '0;
    logic         enter = 1'b0;
    logic         set_mode = 1'b0;
    logic         clear_req, unlocked, lockout, pass, fail, reject, enrolled, programmed;
    logic [1:0]   fail_cnt;
    logic [7:0]   outs;

    assign outs = {clear_req, pass, fail, reject, enrolled, unlocked, lockout, programmed};

    always #5 clk = ~clk;

    pw_verifier #(
        .MAX_FAIL    (MAX_FAIL),
        .OPEN_CYCLES (OPEN_CYCLES),
        .LOCK_CYCLES (LOCK_CYCLES)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .entry      (entry),
        .enter      (enter),
        .set_mode   (set_mode),
        .clear_req  (clear_req),
        .unlocked   (unlocked),
        .lockout    (lockout),
        .pass       (pass),
        .fail       (fail),
        .reject     (reject),
        .enrolled   (enrolled),
        .programmed (programmed),
        .fail_cnt   (fail_cnt)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: mode 0 idle, 1 open, 2 lockout; m_remain = level cycles left incl. current
    logic [127:0] m_stored;
    bit           m_prog;
    int           m_fc;
    int           m_mode;
    int           m_remain;

    typedef struct {
        string        name;
        logic [127:0] e;
        bit           s;
        logic [7:0]   exp_o;
        logic [1:0]   exp_fc;
    } vec_t;

    vec_t         tbl[11];
    logic [127:0] pool[3];
    logic [7:0]   go;
    logic [1:0]   gf;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ev(input bit c, p, f, r, en, u, l, g);
        return {c, p, f, r, en, u, l, g};
    endfunction

    function automatic logic [127:0] pw(input logic [127:0] digits, input int n);
        logic [127:0] r;
        r = digits;
        for (int i = n; i < 32; i++) r[4*i +: 4] = 4'hF;
        return r;
    endfunction

    function automatic logic [127:0] rand_pw(input int n);
        logic [127:0] r;
        r = {128{1'b1}};
        for (int i = 0; i < n; i++) r[4*i +: 4] = 4'($urandom % 10);
        return r;
    endfunction

    function automatic bit m_valid(input logic [127:0] e);
        int n;
        bit run;
        n   = 0;
        run = 1'b1;
        for (int i = 0; i < 32; i++) begin
            if (run && e[4*i +: 4] <= 4'd9) n++;
            else run = 1'b0;
        end
        if (n < 4) return 1'b0;
        for (int i = n; i < 32; i++)
            if (e[4*i +: 4] != 4'hF) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_stored = {128{1'b1}};
        m_prog   = 1'b0;
        m_fc     = 0;
        m_mode   = 0;
        m_remain = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (m_mode != 0) begin
            m_remain--;
            if (m_remain == 0) begin
                if (m_mode == 2) m_fc = 0;
                m_mode = 0;
            end
        end
        chk("level", {outs, fail_cnt},
            {ev(0, 0, 0, 0, 0, m_mode == 1, m_mode == 2, m_prog), 2'(m_fc)});
    endtask

    task automatic txn(input logic [127:0] e, input bit s,
                       output logic [7:0] got_o, output logic [1:0] got_fc);
        bit from_open, vp, vf, vr, ven;
        entry    = e;
        set_mode = s;
        enter    = 1'b1;
        if (m_mode == 2) begin
            step();
            enter    = 1'b0;
            set_mode = 1'b0;
            got_o    = outs;
            got_fc   = fail_cnt;
        end else begin
            from_open = (m_mode == 1);
            @(posedge clk);
            #1;
            enter    = 1'b0;
            set_mode = 1'b0;
            entry    = {$urandom, $urandom, $urandom, $urandom};
            chk("check_cycle", {outs, fail_cnt}, {ev(0, 0, 0, 0, 0, 0, 0, m_prog), 2'(m_fc)});
            vp = 0; vf = 0; vr = 0; ven = 0;
            if (!m_valid(e)) begin
                vr = 1;
                m_mode = from_open ? 1 : 0;
            end else if (s && (!m_prog || from_open)) begin
                ven = 1; m_stored = e; m_prog = 1; m_mode = 0;
            end else if (s) begin
                vr = 1; m_mode = 0;
            end else if (from_open) begin
                m_mode = 0;
            end else if (!m_prog) begin
                vr = 1; m_mode = 0;
            end else if (e == m_stored) begin
                vp = 1; m_fc = 0; m_mode = 1; m_remain = OPEN_CYCLES;
            end else begin
                vf = 1;
                m_fc = (m_fc < MAX_FAIL) ? m_fc + 1 : MAX_FAIL;
                if (m_fc == MAX_FAIL) begin
                    m_mode = 2; m_remain = LOCK_CYCLES;
                end else begin
                    m_mode = 0;
                end
            end
            @(posedge clk);
            #1;
            chk("decision", {outs, fail_cnt},
                {ev(1, vp, vf, vr, ven, m_mode == 1, m_mode == 2, m_prog), 2'(m_fc)});
            got_o  = outs;
            got_fc = fail_cnt;
        end
    endtask

    task automatic do_reset(input string name);
        rstn = 1'b0;
        #1;
        chk(name, {outs, fail_cnt}, 16'h0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{"verify_unprog",  pw(128'h1234, 4),     1'b0, 8'b1001_0000, 2'd0};
        tbl[1]  = '{"three_digits",   pw(128'h123, 3),      1'b1, 8'b1001_0000, 2'd0};
        tbl[2]  = '{"two_digits_1F",  pw(128'h1F23, 4),     1'b1, 8'b1001_0000, 2'd0};
        tbl[3]  = '{"hex_digit_A",    pw(128'hA123, 4),     1'b1, 8'b1001_0000, 2'd0};
        tbl[4]  = '{"nonF_above",     pw(128'h1F1234, 6),   1'b1, 8'b1001_0000, 2'd0};
        tbl[5]  = '{"enroll_1234",    pw(128'h1234, 4),     1'b1, 8'b1000_1001, 2'd0};
        tbl[6]  = '{"reenroll_idle",  pw(128'h5555, 4),     1'b1, 8'b1001_0001, 2'd0};
        tbl[7]  = '{"wrong_9999",     pw(128'h9999, 4),     1'b0, 8'b1010_0001, 2'd1};
        tbl[8]  = '{"invalid_keepfc", pw(128'h123, 3),      1'b0, 8'b1001_0001, 2'd1};
        tbl[9]  = '{"wrong_99999",    pw(128'h99999, 5),    1'b0, 8'b1010_0001, 2'd2};
        tbl[10] = '{"pass_1234",      pw(128'h1234, 4),     1'b0, 8'b1100_0101, 2'd0};

        model_reset();
        #2;
        chk("reset_state", {outs, fail_cnt}, 16'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        step();

        for (int i = 0; i < 11; i++) begin
            txn(tbl[i].e, tbl[i].s, go, gf);
            chk(tbl[i].name, {go, gf}, {tbl[i].exp_o, tbl[i].exp_fc});
        end

        // unlocked must stay high for exactly OPEN_CYCLES cycles
        repeat (OPEN_CYCLES) step();
        chk("open_expired", {unlocked, fail_cnt}, 16'h0);

        for (int i = 0; i < 3; i++) txn(pw(128'h9999, 4), 1'b0, go, gf);
        chk("lockout_entered", {go, gf}, {8'b1010_0011, 2'd3});
        txn(pw(128'h1234, 4), 1'b0, go, gf);
        while (m_mode != 0) step();
        chk("lockout_exit", {lockout, fail_cnt}, 16'h0);

        txn(pw(128'h1234, 4), 1'b0, go, gf);
        repeat (10) step();
        txn(pw(128'h5678, 4), 1'b1, go, gf);
        chk("enroll_in_open", go, 8'b1000_1001);
        txn(pw(128'h1234, 4), 1'b0, go, gf);
        chk("old_pw_fails", {go, gf}, {8'b1010_0001, 2'd1});
        txn(pw(128'h5678, 4), 1'b0, go, gf);
        chk("new_pw_passes", {go, gf}, {8'b1100_0101, 2'd0});
        repeat (5) step();
        txn(pw(128'h12, 2), 1'b0, go, gf);
        chk("reject_stays_open", go, 8'b1001_0101);
        repeat (3) step();
        txn(pw(128'h5678, 4), 1'b0, go, gf);
        chk("relock", go, 8'b1000_0001);

        txn(pw(128'h5678, 4), 1'b0, go, gf);
        while (m_remain > 1) step();
        txn(pw(128'h5678, 4), 1'b0, go, gf);
        chk("relock_at_expiry", go, 8'b1000_0001);

        entry = pw(128'h5678, 4);
        enter = 1'b1;
        @(posedge clk);
        #1;
        enter = 1'b0;
        do_reset("reset_in_check");
        txn(pw(128'h5678, 4), 1'b1, go, gf);
        txn(pw(128'h5678, 4), 1'b0, go, gf);
        repeat (3) step();
        do_reset("reset_in_open");
        txn(pw(128'h5678, 4), 1'b0, go, gf);
        chk("pw_lost_after_reset", go, 8'b1001_0000);

        pool[0] = pw(128'h1234, 4);
        pool[1] = pw(128'h87654321, 8);
        pool[2] = rand_pw(32);
        for (int it = 0; it < 60; it++) begin
            logic [127:0] e;
            int r;
            r = int'($urandom % 8);
            if (r == 0)      e = {$urandom, $urandom, $urandom, $urandom};
            else if (r == 1) e = rand_pw(int'($urandom_range(1, 6)));
            else             e = pool[$urandom % 3];
            txn(e, ($urandom % 4) == 0, go, gf);
            if (m_mode == 2 || (m_mode == 1 && ($urandom % 2) == 1)) begin
                while (m_mode != 0) step();
            end else begin
                repeat ($urandom_range(0, 3)) step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pw_verifier.md
# pw_verifier

Downstream consumer of the 128-bit keypad entry register in the door-lock datapath. It receives the entered password when the user presses confirm, and either enrolls it as the stored password or compares it against the stored one. It drives the door-unlock and lockout outputs, counts consecutive failures, and pulses `clear_req` back to the entry register's synchronous clear (`mem_rst`) after every decision.

## Interface
- `MAX_FAIL`, default 3: consecutive failed verifies that trigger lockout.
- `OPEN_CYCLES`, default 500: cycles `unlocked` stays high after a pass.
- `LOCK_CYCLES`, default 1000: cycles `lockout` stays high.
- `clk`  in  1  clock; all logic on rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `entry`  in  128  entered password.
  - Nibble 0 is the most recent digit.
  - Unused upper nibbles are 4'hF.
- `enter`  in  1  confirm strobe, one cycle.
- `set_mode`  in  1  enroll request, sampled with `enter`.
- `clear_req`  out  1  one-cycle pulse to the entry register's `mem_rst`.
- `unlocked`  out  1  door open.
- `lockout`  out  1  keypad locked out.
- `pass`, `fail`, `reject`, `enrolled`  out  1 each  one-cycle result pulses.
- `programmed`  out  1  a stored password exists.
- `fail_cnt`  out  $clog2(MAX_FAIL+1)  consecutive failure count.

## Operation
- States: IDLE, CHECK, OPEN, LOCKOUT.
- Reset values:
  - State is IDLE.
  - All outputs are 0; `fail_cnt` is 0.
  - Stored password is 128'hFFFF…F and `programmed` is 0.
- `enter` is accepted only in IDLE and OPEN and is ignored in CHECK and LOCKOUT.
- On an accepted `enter`, `entry`, `set_mode` and the accepting state are snapshotted, then the block moves to CHECK. All decisions use the snapshot only.
- Entry validity:
  - `ndig` = count of contiguous nibbles from nibble 0 with value ≤ 9.
  - The entry is valid iff `ndig` ≥ 4 and every nibble at or above `ndig` equals 4'hF.
- Decision in CHECK, first matching rule wins:
  1. Entry invalid → `reject`; return to the accepting state. If that state was OPEN, the OPEN timer continues.
  2. `set_mode`=1 and (`programmed`=0 or accepted from OPEN) → store the entry, set `programmed`=1, pulse `enrolled`. Go to IDLE (relock).
  3. `set_mode`=1 otherwise → `reject`, go to IDLE.
  4. Verify accepted from OPEN → relock: no pulse besides `clear_req`, go to IDLE.
  5. `programmed`=0 → `reject`, go to IDLE.
  6. Snapshot == stored (full 128-bit compare) → `pass`, clear `fail_cnt`, go to OPEN.
  7. Mismatch → `fail`, increment `fail_cnt`. If the new count equals `MAX_FAIL`, go to LOCKOUT; otherwise go to IDLE.
- `clear_req` pulses together with every decision pulse, including a silent relock.
- OPEN:
  - `unlocked`=1 for exactly `OPEN_CYCLES` cycles, then the block goes to IDLE.
  - An `enter` arriving during OPEN suspends the timer through CHECK.
- LOCKOUT:
  - `lockout`=1 for exactly `LOCK_CYCLES` cycles.
  - `fail_cnt` holds `MAX_FAIL` during lockout and clears on exit to IDLE.
- `fail_cnt` saturates at `MAX_FAIL`. `reject` never changes it.

## Timing
- `enter` sampled high at edge N (state IDLE or OPEN) → state is CHECK during cycle N+1.
- Result pulse and `clear_req` are high during cycle N+2 only. The new state (`unlocked`/`lockout` levels) starts in cycle N+2.
- Total latency from `enter` to decision is 2 cycles. Every output is registered.
- The OPEN or LOCKOUT level is high for cycles N+2 … N+1+COUNT, and the state is IDLE at N+2+COUNT.
- `enter` held high for multiple cycles counts once per acceptance. A new `enter` is accepted only in a cycle where the state is IDLE or OPEN.
- `enter` arriving in the same cycle the OPEN timer expires is accepted as a verify from OPEN, so it relocks.
- `rstn` asserted mid-operation (any state, including CHECK) immediately forces the reset values. The stored password is lost.

## Structure
- Shared package `doorlock_pkg` holds:
  - the state enum;
  - `PW_EMPTY` = 128'hFFFF…F;
  - `DIGIT_BLANK` = 4'hF;
  - `MIN_DIGITS` = 4.
  The entry register also uses `PW_EMPTY` for its reset value.
- One sub-module: `pw_digit_count`. It is combinational, takes a 128-bit entry, and outputs `ndig` (6 bits) and `valid`.
- One shared down-counter, sized for max(`OPEN_CYCLES`, `LOCK_CYCLES`), serves both OPEN and LOCKOUT.

## Test plan
- **Reset then verify.** Reset; enter `entry`=…FFF1234, `set_mode`=0 → `reject` and `clear_req` in cycle N+2; `programmed`=0; `unlocked`=0.
- **Enroll then pass.** Enroll …FFF1234 with `set_mode`=1 → `enrolled`, `programmed`=1. Verify …FFF1234 → `pass` at N+2; `unlocked` high for exactly 500 cycles; `fail_cnt`=0.
- **Lockout.** With 1234 enrolled, verify 9999 three times → `fail_cnt` goes 1, 2, then `lockout`=1 for 1000 cycles. `enter` is ignored during lockout. `fail_cnt`=0 and IDLE afterwards.
- **Invalid entries.**
  - …FFF123 (3 digits) → `reject`, `fail_cnt` unchanged.
  - …FF1F23 (non-F above `ndig`) → `reject`.
  - …FFFA123 → `reject`.
- **Re-enroll and relock in OPEN.**
  - In OPEN, `set_mode`=1 with 5678 → `enrolled`, IDLE. Verify 1234 → `fail`; verify 5678 → `pass`.
  - In OPEN, `set_mode`=0 → relock: IDLE, `clear_req` only.
- **Async reset mid-sequence.** Assert `rstn`=0 during CHECK and during OPEN → all outputs 0 immediately. After release, the old password no longer passes and `programmed`=0.
